// File: rtl/mem_bus_responder.sv
// Single-port word RAM behind a request/ack bus with per-request wait states.
// Optional out-of-range detection is enabled by defining MEMRESP_OOR_ERR_EN.
module mem_bus_responder #(
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned DEF_WAIT  = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:1] m_addr,
  input  logic [15:0] m_data_out,
  output logic [15:0] m_data_in,
  input  logic        m_access,
  output logic        m_ack,
  input  logic        m_wr_en,
  input  logic [1:0]  m_bytesel,
  input  logic [3:0]  wait_states,
  input  logic        use_def,
  output logic        busy,
  output logic        oor_err
);

  localparam int unsigned Depth = 2 ** ADDR_BITS;

  typedef enum logic [1:0] {StIdle, StWait, StAck, StRecover} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]   addr_q;
  logic [15:0]            wdata_q;
  logic                   wr_q;
  logic [1:0]             be_q;
  logic                   oor_q;
  logic [15:0]            rdata_q;
  logic [15:0]            mem [Depth];

  logic [3:0]             w_eff;
  logic                   accept;
  logic                   enter_ack;
  logic                   in_oor;
  logic [ADDR_BITS-1:0]   cur_idx;
  logic [15:0]            cur_wdata;
  logic                   cur_wr;
  logic [1:0]             cur_be;
  logic                   cur_oor;

  assign w_eff  = (wait_states == 4'd0 && use_def) ? 4'(DEF_WAIT) : wait_states;
  assign accept = (state_q == StIdle) && m_access;

  // A zero-wait request completes on the acceptance edge itself, so the live
  // inputs are used then; otherwise the captured copy is used.
  assign enter_ack = (accept && w_eff == 4'd0) || (state_q == StWait && cnt_q == 4'd1);
  assign cur_idx   = accept ? m_addr[ADDR_BITS:1] : addr_q;
  assign cur_wdata = accept ? m_data_out : wdata_q;
  assign cur_wr    = accept ? m_wr_en : wr_q;
  assign cur_be    = accept ? m_bytesel : be_q;
  assign cur_oor   = accept ? in_oor : oor_q;

`ifdef MEMRESP_OOR_ERR_EN
  assign in_oor  = |m_addr[19:ADDR_BITS+1];
  assign oor_err = (state_q == StAck) && oor_q;
`else
  logic unused_upper_addr;
  assign unused_upper_addr = ^m_addr[19:ADDR_BITS+1];
  assign in_oor  = 1'b0;
  assign oor_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (m_access) begin
          if (w_eff == 4'd0) begin
            state_d = StAck;
          end else begin
            state_d = StWait;
            cnt_d   = w_eff;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd1) begin
          state_d = StAck;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StAck:     state_d = StRecover;
      StRecover: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 16'h0000;
      wr_q    <= 1'b0;
      be_q    <= 2'b00;
      oor_q   <= 1'b0;
      rdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= m_addr[ADDR_BITS:1];
        wdata_q <= m_data_out;
        wr_q    <= m_wr_en;
        be_q    <= m_bytesel;
        oor_q   <= in_oor;
      end
      if (enter_ack && !cur_wr) begin
        rdata_q <= cur_oor ? 16'hFFFF : mem[cur_idx];
      end
    end
  end

  // RAM contents survive reset; reset only suppresses a pending write.
  always_ff @(posedge clk) begin
    if (!reset && enter_ack && cur_wr && !cur_oor) begin
      if (cur_be[0]) mem[cur_idx][7:0]  <= cur_wdata[7:0];
      if (cur_be[1]) mem[cur_idx][15:8] <= cur_wdata[15:8];
    end
  end

  assign m_ack     = (state_q == StAck);
  assign busy      = (state_q != StIdle);
  assign m_data_in = rdata_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed self-checking bench for mem_bus_responder (ADDR_BITS=10, DEF_WAIT=2).
module tb_mem_bus_responder;

  logic        clk;
  logic        reset;
  logic [19:1] m_addr;
  logic [15:0] m_data_out;
  logic [15:0] m_data_in;
  logic        m_access;
  logic        m_ack;
  logic        m_wr_en;
  logic [1:0]  m_bytesel;
  logic [3:0]  wait_states;
  logic        use_def;
  logic        busy;
  logic        oor_err;

  int checks = 0;
  int errors = 0;

  mem_bus_responder #(
    .ADDR_BITS(10),
    .DEF_WAIT (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .m_addr     (m_addr),
    .m_data_out (m_data_out),
    .m_data_in  (m_data_in),
    .m_access   (m_access),
    .m_ack      (m_ack),
    .m_wr_en    (m_wr_en),
    .m_bytesel  (m_bytesel),
    .wait_states(wait_states),
    .use_def    (use_def),
    .busy       (busy),
    .oor_err    (oor_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one request and watches 24 cycles after acceptance. lat is the
  // cycle index (1 = cycle right after acceptance) of the first ack, -1 if none.
  task automatic run_req(input logic [19:1] addr, input logic [15:0] data, input logic wr,
                         input logic [1:0] be, input logic [3:0] ws, input logic ud,
                         input logic hold, output int lat, output int width,
                         output logic [15:0] rdata, output logic oor_seen);
    @(negedge clk);
    m_addr = addr; m_data_out = data; m_wr_en = wr; m_bytesel = be;
    wait_states = ws; use_def = ud; m_access = 1'b1;
    @(posedge clk);
    lat = -1; width = 0; rdata = 16'h0000; oor_seen = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (!hold) begin
        m_access = 1'b0; m_addr = ~addr; m_data_out = ~data; m_wr_en = ~wr;
        m_bytesel = ~be; wait_states = 4'hF;
      end
      if (m_ack) begin
        if (lat < 0) begin
          lat = c; rdata = m_data_in; oor_seen = oor_err;
        end
        width++;
        m_access = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; m_access = 1'b0; m_addr = '0; m_data_out = '0; m_wr_en = 1'b0;
    m_bytesel = 2'b00; wait_states = 4'd0; use_def = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (m_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", m_ack); end
    checks++; if (m_data_in !== 16'h0000) begin errors++; $display("FAIL reset_rdata got %h exp 0000", m_data_in); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (oor_err !== 1'b0) begin errors++; $display("FAIL reset_oor got %b exp 0", oor_err); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int lat, width; logic [15:0] rd; logic oor;
    run_req(19'h00014, 16'hABCD, 1'b1, 2'b11, 4'd0, 1'b0, 1'b1, lat, width, rd, oor);
    checks++; if (lat !== 1) begin errors++; $display("FAIL basic_wr_lat got %0d exp 1", lat); end
    checks++; if (width !== 1) begin errors++; $display("FAIL basic_wr_width got %0d exp 1", width); end
    checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL basic_wr_rdata got %h exp 0000", rd); end
    run_req(19'h00014, 16'h0000, 1'b0, 2'b11, 4'd0, 1'b0, 1'b1, lat, width, rd, oor);
    checks++; if (lat !== 1) begin errors++; $display("FAIL basic_rd_lat got %0d exp 1", lat); end
    checks++; if (width !== 1) begin errors++; $display("FAIL basic_rd_width got %0d exp 1", width); end
    checks++; if (rd !== 16'hABCD) begin errors++; $display("FAIL basic_rd_data got %h exp abcd", rd); end
    checks++; if (oor !== 1'b0) begin errors++; $display("FAIL basic_rd_oor got %b exp 0", oor); end
  endtask

  task automatic test_bytesel();
    logic [15:0] wdat [3] = '{16'h1234, 16'h5600, 16'hFFFF};
    logic [1:0]  wbe  [3] = '{2'b01, 2'b10, 2'b00};
    logic [15:0] wexp [3] = '{16'hAB34, 16'h5634, 16'h5634};
    int lat, width; logic [15:0] rd; logic oor;
    for (int i = 0; i < 3; i++) begin
      run_req(19'h00014, wdat[i], 1'b1, wbe[i], 4'd0, 1'b0, 1'b1, lat, width, rd, oor);
      checks++; if (lat !== 1) begin errors++; $display("FAIL bytesel_wr_lat[%0d] got %0d exp 1", i, lat); end
      run_req(19'h00014, 16'h0000, 1'b0, 2'b11, 4'd0, 1'b0, 1'b1, lat, width, rd, oor);
      checks++; if (rd !== wexp[i]) begin errors++; $display("FAIL bytesel_rd[%0d] got %h exp %h", i, rd, wexp[i]); end
    end
  endtask

  // Held read with 3 wait states, then W switches to 0 while access stays high.
  task automatic test_wait_states();
    logic exp_ack, exp_busy;
    @(negedge clk);
    m_addr = 19'h00014; m_wr_en = 1'b0; m_bytesel = 2'b11; wait_states = 4'd3;
    use_def = 1'b0; m_access = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      exp_ack  = (c == 4) || (c == 7);
      exp_busy = (c != 6);
      checks++; if (m_ack !== exp_ack) begin errors++; $display("FAIL ws_ack[c%0d] got %b exp %b", c, m_ack, exp_ack); end
      checks++; if (busy !== exp_busy) begin errors++; $display("FAIL ws_busy[c%0d] got %b exp %b", c, busy, exp_busy); end
      if (c == 4) begin
        checks++; if (m_data_in !== 16'h5634) begin errors++; $display("FAIL ws_rdata got %h exp 5634", m_data_in); end
        wait_states = 4'd0;
      end
    end
    m_access = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_use_def();
    int lat, width; logic [15:0] rd; logic oor;
    // Access drops and inputs scramble right after acceptance.
    run_req(19'h00003, 16'h2468, 1'b1, 2'b11, 4'd0, 1'b1, 1'b0, lat, width, rd, oor);
    checks++; if (lat !== 3) begin errors++; $display("FAIL usedef_lat got %0d exp 3", lat); end
    checks++; if (width !== 1) begin errors++; $display("FAIL usedef_width got %0d exp 1", width); end
    run_req(19'h00003, 16'h0000, 1'b0, 2'b11, 4'd0, 1'b0, 1'b1, lat, width, rd, oor);
    checks++; if (lat !== 1) begin errors++; $display("FAIL usedef_rd_lat got %0d exp 1", lat); end
    checks++; if (rd !== 16'h2468) begin errors++; $display("FAIL usedef_rd got %h exp 2468", rd); end
  endtask

  task automatic test_reset_in_wait();
    int lat, width, acks; logic [15:0] rd; logic oor;
    run_req(19'h00007, 16'h1357, 1'b1, 2'b11, 4'd0, 1'b0, 1'b1, lat, width, rd, oor);
    @(negedge clk);
    m_addr = 19'h00007; m_data_out = 16'h00FF; m_wr_en = 1'b1; m_bytesel = 2'b11;
    wait_states = 4'd5; use_def = 1'b0; m_access = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1; m_access = 1'b0;
    @(negedge clk);
    checks++; if (m_ack !== 1'b0) begin errors++; $display("FAIL rstw_ack got %b exp 0", m_ack); end
    checks++; if (m_data_in !== 16'h0000) begin errors++; $display("FAIL rstw_rdata got %h exp 0000", m_data_in); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstw_busy got %b exp 0", busy); end
    checks++; if (oor_err !== 1'b0) begin errors++; $display("FAIL rstw_oor got %b exp 0", oor_err); end
    @(negedge clk);
    reset = 1'b0;
    acks = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (m_ack) acks++;
    end
    checks++; if (acks !== 0) begin errors++; $display("FAIL rstw_noack got %0d exp 0", acks); end
    run_req(19'h00007, 16'h0000, 1'b0, 2'b11, 4'd0, 1'b0, 1'b1, lat, width, rd, oor);
    checks++; if (rd !== 16'h1357) begin errors++; $display("FAIL rstw_ram got %h exp 1357", rd); end
  endtask

  task automatic test_oor();
    int lat, width; logic [15:0] rd; logic oor;
    logic [15:0] exp_rd, exp_after;
    logic        exp_oor;
`ifdef MEMRESP_OOR_ERR_EN
    exp_rd = 16'hFFFF; exp_oor = 1'b1; exp_after = 16'h0000;
`else
    exp_rd = 16'h0000; exp_oor = 1'b0; exp_after = 16'hBEEF;
`endif
    run_req(19'h00000, 16'h0000, 1'b1, 2'b11, 4'd0, 1'b0, 1'b1, lat, width, rd, oor);
    run_req(19'h00400, 16'h0000, 1'b0, 2'b11, 4'd0, 1'b0, 1'b1, lat, width, rd, oor);
    checks++; if (lat !== 1) begin errors++; $display("FAIL oor_lat got %0d exp 1", lat); end
    checks++; if (rd !== exp_rd) begin errors++; $display("FAIL oor_rdata got %h exp %h", rd, exp_rd); end
    checks++; if (oor !== exp_oor) begin errors++; $display("FAIL oor_pulse got %b exp %b", oor, exp_oor); end
    run_req(19'h00400, 16'hBEEF, 1'b1, 2'b11, 4'd0, 1'b0, 1'b1, lat, width, rd, oor);
    checks++; if (lat !== 1) begin errors++; $display("FAIL oor_wr_lat got %0d exp 1", lat); end
    run_req(19'h00000, 16'h0000, 1'b0, 2'b11, 4'd0, 1'b0, 1'b1, lat, width, rd, oor);
    checks++; if (rd !== exp_after) begin errors++; $display("FAIL oor_wr_effect got %h exp %h", rd, exp_after); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bytesel();
    test_wait_states();
    test_use_def();
    test_reset_in_wait();
    test_oor();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
